// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch unit with a small in-order instruction queue
//
// Purpose:
//   Issues one word-aligned instruction read at a time. Returned words are
//   queued with their address and presented to the decoder from registered
//   head state. A redirect flushes the queue, drops any in-flight data and
//   restarts fetching at the new address.
//
// Parameters:
//   RESET_PC : first fetch address after reset
//   DEPTH    : queue entries (power of 2, 2..8)
//
// Ports:
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   mem_req, mem_addr : read request and word address (held until mem_ack)
//   mem_ack, mem_rdata: read completion and data
//   inst, inst_pc     : head-of-queue instruction word and its address
//   inst_valid        : head entry present
//   inst_take         : decoder consumes the head this cycle
//   redirect          : flush and restart fetch at redirect_pc
//   redirect_pc       : restart address
//   inst_misaligned   : head entry is a misaligned-target fault marker
//
// Build option:
//   FETCH_MISALIGN_FAULT_EN : a redirect to a non-word-aligned target queues a
//   single fault marker and halts fetching until the next redirect. When not
//   defined the low target bits are cleared and inst_misaligned is 0.

module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_take,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_misaligned
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [31:0]   addr_q;
    logic [AW:0]   count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          halt;

    logic [31:0]   q_data [DEPTH];
    logic [31:0]   q_pc   [DEPTH];

    logic          pop;
    logic          push;
    logic          start;
    logic          fault;
    logic [31:0]   target;
    logic [AW:0]   occ_after_pop;

    assign inst_valid = (count != '0);
    assign pop        = inst_take && inst_valid;
    // Data returning while a redirect is asserted belongs to the old stream.
    assign push       = (state == S_WAIT) && mem_ack && !redirect;
    assign target     = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_FAULT_EN
    assign fault = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign fault = 1'b0;
`endif

    // A pop in the same cycle frees a slot, so the next request can go out
    // right after the decoder takes from a full queue.
    assign occ_after_pop = count - {{AW{1'b0}}, pop};
    assign start = (state == S_IDLE) && !redirect && !halt && (occ_after_pop < DEPTH_C);

    assign mem_req  = (state == S_WAIT) || (state == S_DISCARD);
    assign mem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            addr_q   <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            halt     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_WAIT;
                        addr_q <= fetch_pc;
                    end
                end
                S_WAIT: begin
                    // An ack coincident with redirect completes the request;
                    // its data is simply not pushed.
                    if (mem_ack) begin
                        state <= S_IDLE;
                    end else if (redirect) begin
                        state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (mem_ack) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (redirect) begin
                fetch_pc <= target;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (redirect) begin
                head <= '0;
                if (fault) begin
                    tail  <= {{(AW-1){1'b0}}, 1'b1};
                    count <= {{AW{1'b0}}, 1'b1};
                    halt  <= 1'b1;
                end else begin
                    tail  <= '0;
                    count <= '0;
                    halt  <= 1'b0;
                end
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            end
        end
    end

    // Entry storage needs no reset: outputs are gated by inst_valid.
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [31:0]   wr_pc;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = tail;
        wr_data = mem_rdata;
        wr_pc   = addr_q;
        if (fault) begin
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = '0;
            wr_pc   = redirect_pc;
        end else if (push) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_data[wr_idx] <= wr_data;
            q_pc[wr_idx]   <= wr_pc;
        end
    end

    assign inst    = inst_valid ? q_data[head] : 32'd0;
    assign inst_pc = inst_valid ? q_pc[head]   : 32'd0;

`ifdef FETCH_MISALIGN_FAULT_EN
    logic q_mis [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            q_mis[wr_idx] <= fault;
        end
    end

    assign inst_misaligned = inst_valid && q_mis[head];
`else
    assign inst_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue

module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_take;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_misaligned;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_valid;
    logic        w_mis;

    logic        auto_ack;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
        .inst_take(inst_take), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_misaligned(inst_misaligned)
    );

    // Second instance: wrap-around of the fetch PC, memory acks immediately,
    // decoder always takes.
    fetch_queue #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst),
        .mem_req(w_req), .mem_addr(w_addr),
        .mem_ack(w_req), .mem_rdata(32'h0),
        .inst(w_inst), .inst_pc(w_inst_pc), .inst_valid(w_valid),
        .inst_take(1'b1), .redirect(1'b0), .redirect_pc(32'h0),
        .inst_misaligned(w_mis)
    );

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are pulses, memory responds in the request cycle.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        inst_take = 1'b0;
        redirect  = 1'b0;
        if (auto_ack) begin
            mem_ack   = mem_req;
            mem_rdata = data_of(mem_addr);
        end else begin
            mem_ack   = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; inst_take = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; auto_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_mis", {31'd0, inst_misaligned}, 32'd0);

        // Stale ack right after reset release must be ignored.
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        check("c0_req", {31'd0, mem_req}, 32'd0);
        auto_ack = 1'b1;
        step();
        check("c1_req", {31'd0, mem_req}, 32'd1);
        check("c1_addr", mem_addr, 32'h0);
        check("c1_valid", {31'd0, inst_valid}, 32'd0);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        step();
        check("c2_valid", {31'd0, inst_valid}, 32'd1);
        check("c2_pc", inst_pc, 32'h0);
        check("c2_inst", inst, data_of(32'h0));
        check("c2_req", {31'd0, mem_req}, 32'd0);
        step();
        check("c3_addr", mem_addr, 32'h4);
        check("c3_req", {31'd0, mem_req}, 32'd1);
        check("wrap_req1", {31'd0, w_req}, 32'd1);
        check("wrap_addr1", w_addr, 32'h0);
        step();
        check("c4_req", {31'd0, mem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req", {31'd0, mem_req}, 32'd0);
        end

        // One take from a full queue releases the next request.
        inst_take = 1'b1; auto_ack = 1'b0;
        step();
        check("take_req", {31'd0, mem_req}, 32'd1);
        check("take_addr", mem_addr, 32'h8);
        check("take_pc", inst_pc, 32'h4);

        // Redirect while 0x8 is outstanding.
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        check("disc_req", {31'd0, mem_req}, 32'd1);
        check("disc_addr", mem_addr, 32'h8);
        check("disc_valid", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        check("late_req", {31'd0, mem_req}, 32'd0);
        check("late_valid", {31'd0, inst_valid}, 32'd0);
        auto_ack = 1'b1;
        step();
        check("redir_addr", mem_addr, 32'h100);
        check("redir_req", {31'd0, mem_req}, 32'd1);
        step();
        check("redir_valid", {31'd0, inst_valid}, 32'd1);
        check("redir_pc", inst_pc, 32'h100);
        check("redir_inst", inst, data_of(32'h100));
        step();
        check("c13_addr", mem_addr, 32'h104);

        // Redirect + ack + take in the same cycle.
        inst_take = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        step();
        check("combo_valid", {31'd0, inst_valid}, 32'd0);
        check("combo_req", {31'd0, mem_req}, 32'd0);
        step();
        check("combo_addr", mem_addr, 32'h40);
        step();
        check("combo_pc", inst_pc, 32'h40);

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 32'h102;
        step();
`ifdef FETCH_MISALIGN_FAULT_EN
        check("mis_valid", {31'd0, inst_valid}, 32'd1);
        check("mis_flag", {31'd0, inst_misaligned}, 32'd1);
        check("mis_pc", inst_pc, 32'h102);
        check("mis_inst", inst, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("mis_halt_req", {31'd0, mem_req}, 32'd0);
            step();
        end
`else
        check("mis_valid", {31'd0, inst_valid}, 32'd0);
        check("mis_flag", {31'd0, inst_misaligned}, 32'd0);
        step();
        check("mis_req", {31'd0, mem_req}, 32'd1);
        check("mis_addr", mem_addr, 32'h100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter DEPTH, default 2, queue entries (power of 2, 2..8).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL provide port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL provide port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL provide port mem_req  output  1  instruction read request.
REQ-007 SHALL provide port mem_addr  output  32  read word address, bits [1:0] always 0.
REQ-008 SHALL provide port mem_ack  input  1  read data valid; completes the outstanding request.
REQ-009 SHALL provide port mem_rdata  input  32  read data, sampled only when mem_ack=1.
REQ-010 SHALL provide port inst  output  32  head-of-queue instruction word to the decoder.
REQ-011 SHALL provide port inst_pc  output  32  address of inst.
REQ-012 SHALL provide port inst_valid  output  1  head entry present.
REQ-013 SHALL provide port inst_take  input  1  decoder consumes head this cycle.
REQ-014 SHALL provide port redirect  input  1  flush and restart fetch (taken jump/branch).
REQ-015 SHALL provide port redirect_pc  input  32  restart address.
REQ-016 SHALL provide port inst_misaligned  output  1  head entry is a misaligned-target fault marker.

Function
REQ-017 SHALL allow at most one outstanding memory request; mem_req and mem_addr SHALL hold stable from assertion until the cycle mem_ack=1, inclusive.
REQ-018 SHALL run FSM IDLE / WAIT / DISCARD: IDLE->WAIT when occupancy+outstanding < DEPTH; WAIT->IDLE on mem_ack; WAIT->DISCARD on redirect without same-cycle mem_ack; DISCARD->IDLE on mem_ack.
REQ-019 SHALL assert mem_req in WAIT and DISCARD only; a new request SHALL start no earlier than the cycle after the previous mem_ack.
REQ-020 SHALL, on mem_ack in WAIT, push {mem_rdata, mem_addr} into the tail and increment fetch PC by 4 (mod 2^32, wrap 32'hFFFF_FFFC -> 0).
REQ-021 SHALL drop mem_rdata on mem_ack in DISCARD and on mem_ack coincident with redirect.
REQ-022 SHALL drive inst/inst_pc/inst_valid from registered head state only (no combinational path from mem_rdata or inst_take); fetch-to-inst_valid latency is 1 cycle after mem_ack.
REQ-023 SHALL pop the head when inst_take=1 and inst_valid=1; inst_take with inst_valid=0 SHALL be ignored.
REQ-024 SHALL support simultaneous push and pop, including at full occupancy (occupancy unchanged).
REQ-025 SHALL, on redirect, empty the queue (inst_valid=0 next cycle) and load fetch PC with {redirect_pc[31:2], 2'b00}; redirect SHALL override a coincident inst_take and push.
REQ-026 SHALL never request when queue occupancy plus outstanding request equals DEPTH.

Reset
REQ-027 SHALL, while rst=1, force mem_req=0, inst_valid=0, inst_misaligned=0, inst=0, inst_pc=0, occupancy=0, FSM=IDLE, fetch PC=RESET_PC.
REQ-028 SHALL abandon any outstanding request on reset; an mem_ack arriving in the first cycle after reset release SHALL be ignored.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_FAULT_EN defined, on redirect with redirect_pc[1:0]!=0, flush, push a single entry with inst=0, inst_pc=redirect_pc, inst_misaligned=1, and halt fetching until the next redirect.
REQ-030 SHALL, without FETCH_MISALIGN_FAULT_EN, clear redirect_pc[1:0] and tie inst_misaligned to 0.

Verification
REQ-031 SHALL cover reset: release rst, mem acks with 1-cycle latency -> mem_addr 0x0, 0x4 requested in order; inst_valid=1 with inst_pc=0x0 one cycle after first ack.
REQ-032 SHALL cover full stall: DEPTH=2, inst_take=0 -> exactly two requests (0x0, 0x4), mem_req stays 0 thereafter; one inst_take -> request 0x8 issued next cycle.
REQ-033 SHALL cover redirect during outstanding request: request 0x8 pending, redirect to 0x100 -> queue empties, late ack data dropped, next mem_addr=0x100, first inst_pc=0x100.
REQ-034 SHALL cover simultaneous redirect+mem_ack+inst_take: redirect to 0x40 -> no push, no pop effect, inst_valid=0 next cycle, next mem_addr=0x40.
REQ-035 SHALL cover wrap-around: RESET_PC=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-036 SHALL cover misalignment: redirect_pc=0x102 -> with macro inst_misaligned=1, inst_pc=0x102, mem_req stays 0; without macro next mem_addr=0x100.
